// File: rtl/vga_scanout_feeder.sv
// vga_scanout_feeder
//   Pixel source for the VGA frame controller. Streams a 1-bpp bitmap from
//   word-wide video RAM, one bit per data_clock_enable pulse, MSB first.
//   Holds a shift word plus one prefetched word, keeps at most one RAM read
//   in flight, and re-aligns to frame start on every vsync falling edge.
// Ports
//   clock             in   system/pixel clock, posedge
//   reset_n           in   asynchronous active-low reset
//   vsync             in   active-low vsync from the frame controller
//   data_clock_enable in   advance to the next pixel bit
//   data              out  current pixel bit
//   mem_rd            out  one-cycle read strobe
//   mem_addr          out  word address, valid while mem_rd=1
//   mem_rdata         in   read data, valid while mem_valid=1
//   mem_valid         in   read-data strobe (latency >= 1 cycle)
//   underrun          out  sticky: word boundary reached with prefetch empty
module vga_scanout_feeder #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  vsync,
  input  logic                  data_clock_enable,
  output logic                  data,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid,
  output logic                  underrun
);

  localparam int unsigned CNT_W       = $clog2(WORD_WIDTH);
  localparam int unsigned FRAME_WORDS = H_ACTIVE * V_ACTIVE / WORD_WIDTH;
  // One extra bit so the fetch address can sit at FRAME_WORDS without wrapping.
  localparam logic [ADDR_WIDTH:0] LP_FRAME_WORDS = (ADDR_WIDTH+1)'(FRAME_WORDS);
  localparam logic [CNT_W-1:0]    LP_BIT_LAST    = CNT_W'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_vsync_d;
  logic [WORD_WIDTH-1:0] r_shift;
  logic                  r_shift_valid;
  logic [WORD_WIDTH-1:0] r_prefetch;
  logic                  r_pref_valid;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [ADDR_WIDTH:0]   r_fetch_addr;
  logic                  r_outstanding;
  logic                  r_drop;
  logic                  r_skip;
  logic                  r_underrun;
  logic                  r_mem_rd;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  logic w_vsync_start;
  logic w_arrival;
  logic w_accept;
  logic w_shift_en;
  logic w_boundary;
  logic w_frame_done;
  logic w_issue;

  assign w_vsync_start = r_vsync_d & ~vsync;
  assign w_arrival     = mem_valid & r_outstanding;
  // A flagged arrival (stale after resync, or late after underrun) is discarded.
  assign w_accept      = w_arrival & ~r_drop & ~r_skip;
  assign w_shift_en    = data_clock_enable & (r_state == ST_RUN) & r_shift_valid;
  assign w_boundary    = w_shift_en & (r_bit_cnt == LP_BIT_LAST);
  // Every frame word has been requested and received: running dry is not an underrun.
  assign w_frame_done  = (r_fetch_addr >= LP_FRAME_WORDS) & ~r_outstanding;
  assign w_issue       = (r_state != ST_IDLE) & (~r_shift_valid | ~r_pref_valid) &
                         ~r_outstanding & (r_fetch_addr < LP_FRAME_WORDS) & ~w_vsync_start;

  assign data     = (r_state == ST_RUN) & r_shift_valid & r_shift[WORD_WIDTH-1];
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign underrun = r_underrun;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_vsync_start) begin
      w_state_next = ST_PRIME;
    end else begin
      case (r_state)
        ST_PRIME: if (r_shift_valid && r_pref_valid) w_state_next = ST_RUN;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync_d     <= 1'b0;
      r_shift       <= '0;
      r_shift_valid <= 1'b0;
      r_prefetch    <= '0;
      r_pref_valid  <= 1'b0;
      r_bit_cnt     <= '0;
      r_fetch_addr  <= '0;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
      r_skip        <= 1'b0;
      r_underrun    <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_addr    <= '0;
    end else begin
      r_vsync_d <= vsync;
      r_mem_rd  <= 1'b0;
      if (w_vsync_start) begin
        r_shift_valid <= 1'b0;
        r_pref_valid  <= 1'b0;
        r_bit_cnt     <= '0;
        r_fetch_addr  <= '0;
        r_underrun    <= 1'b0;
        r_skip        <= 1'b0;
        // A read still in flight belongs to the old frame; a word landing
        // this very cycle is simply not taken.
        r_drop        <= r_outstanding & ~mem_valid;
        r_outstanding <= r_outstanding & ~mem_valid;
      end else begin
        if (w_arrival) begin
          r_outstanding <= 1'b0;
          if (r_drop)      r_drop <= 1'b0;
          else if (r_skip) r_skip <= 1'b0;
        end

        if (w_boundary) begin
          r_bit_cnt <= '0;
          if (r_pref_valid) begin
            r_shift      <= r_prefetch;
            r_pref_valid <= w_accept;
            if (w_accept) r_prefetch <= mem_rdata;
          end else if (w_accept) begin
            r_shift <= mem_rdata;
          end else if (w_frame_done) begin
            r_shift_valid <= 1'b0;
          end else begin
            // Emit a blank word in place of the missing one and discard the
            // late word when it shows up, so later words stay on their slots.
            // Placed after the arrival clear so a new skip wins.
            r_shift    <= '0;
            r_underrun <= 1'b1;
            r_skip     <= 1'b1;
          end
        end else begin
          if (w_shift_en) begin
            r_shift   <= r_shift << 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          if (w_accept) begin
            if (!r_shift_valid) begin
              r_shift       <= mem_rdata;
              r_shift_valid <= 1'b1;
            end else begin
              r_prefetch   <= mem_rdata;
              r_pref_valid <= 1'b1;
            end
          end
        end

        if ((r_state == ST_PRIME) && data_clock_enable) r_underrun <= 1'b1;

        if (w_issue) begin
          r_mem_rd      <= 1'b1;
          r_mem_addr    <= r_fetch_addr[ADDR_WIDTH-1:0];
          r_fetch_addr  <= r_fetch_addr + 1'b1;
          r_outstanding <= 1'b1;
        end
      end
    end
  end

endmodule
